// File: rtl/ysyx_25040111_xbar.sv
// Read-channel crossbar: one read master routed to either the CLINT (mtime) or the memory port.
// Define XBAR_DECERR_EN to answer addresses outside both windows with DECERR instead of forwarding to memory.
module ysyx_25040111_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'd8,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,

    output logic [31:0] c_araddr,
    output logic        c_arvalid,
    input  logic        c_arready,
    input  logic [31:0] c_rdata,
    input  logic        c_rvalid,
    output logic        c_rready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
`ifdef XBAR_DECERR_EN
        ,
        ERR  = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        sel_q, sel_d;

    logic [31:0] clint_off;
    logic        clint_hit;

    // Unsigned offset compare: addresses below the base wrap to huge offsets and never false-hit.
    assign clint_off = m_araddr - CLINT_BASE;
    assign clint_hit = (clint_off < CLINT_SIZE);

`ifdef XBAR_DECERR_EN
    logic [31:0] mem_off;
    logic        mem_hit;

    assign mem_off = m_araddr - MEM_BASE;
    assign mem_hit = (mem_off < MEM_SIZE);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (m_arvalid) begin
                    addr_d = m_araddr;
                    sel_d  = clint_hit;
`ifdef XBAR_DECERR_EN
                    state_d = (clint_hit || mem_hit) ? REQ : ERR;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (sel_q ? c_arready : s_arready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (m_rvalid && m_rready) begin
                    state_d = IDLE;
                end
            end
`ifdef XBAR_DECERR_EN
            ERR: begin
                if (m_rready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end

    // Address stays on both slave buses through RESP; the CLINT muxes its read word from it.
    always_comb begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        c_araddr  = '0;
        c_arvalid = 1'b0;
        c_rready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                m_arready = 1'b1;
            end
            REQ: begin
                c_araddr  = addr_q;
                s_araddr  = addr_q;
                c_arvalid = sel_q;
                s_arvalid = ~sel_q;
            end
            RESP: begin
                c_araddr = addr_q;
                s_araddr = addr_q;
                if (sel_q) begin
                    m_rvalid = c_rvalid;
                    m_rdata  = c_rdata;
                    c_rready = m_rready;
                end else begin
                    m_rvalid = s_rvalid;
                    m_rdata  = s_rdata;
                    m_rresp  = s_rresp;
                    s_rready = m_rready;
                end
            end
`ifdef XBAR_DECERR_EN
            ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b11;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040111_xbar.sv
// Scoreboard bench for ysyx_25040111_xbar with behavioural CLINT and memory slaves.
// Inputs change 1 time unit after the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_ysyx_25040111_xbar;

    logic        clock;
    logic        reset;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] c_araddr;
    logic        c_arvalid;
    logic        c_arready;
    logic [31:0] c_rdata;
    logic        c_rvalid;
    logic        c_rready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    localparam logic [31:0] MTIME_LO = 32'h89ab_cdef;
    localparam logic [31:0] MTIME_HI = 32'h0123_4567;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          clint;
    } sb_item_t;

    sb_item_t    sb_q[$];
    sb_item_t    mon_item;
    sb_item_t    dropped;
    int          checks = 0;
    int          errors = 0;

    bit          rand_mode;
    logic [31:0] rand_word;
    int          mem_ar_wait;
    int          mem_r_lat;
    logic [31:0] mem_data;
    logic [1:0]  mem_resp;
    int          mem_st;
    int          wait_cnt;
    int          lat_cnt;

    bit          s_ar_hs, s_r_hs, c_ar_hs, c_r_hs;
    bit          watch_no_c, watch_no_s;
    int          c_viol, s_viol;

    ysyx_25040111_xbar dut (
        .clock     (clock),
        .reset     (reset),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .c_araddr  (c_araddr),
        .c_arvalid (c_arvalid),
        .c_arready (c_arready),
        .c_rdata   (c_rdata),
        .c_rvalid  (c_rvalid),
        .c_rready  (c_rready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The CLINT picks its read word combinationally from the forwarded address.
    assign c_rdata = rand_mode ? rand_word : (c_araddr[2] ? MTIME_HI : MTIME_LO);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Handshake capture and scoreboard monitor on the falling edge.
    always @(negedge clock) begin
        s_ar_hs = s_arvalid & s_arready;
        s_r_hs  = s_rvalid & s_rready;
        c_ar_hs = c_arvalid & c_arready;
        c_r_hs  = c_rvalid & c_rready;
        if (watch_no_c && c_arvalid) c_viol++;
        if (watch_no_s && (s_arvalid || c_arvalid)) s_viol++;
        if (reset && m_rvalid && m_rready) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_resp", 32'd1, 32'd0);
            end else begin
                mon_item = sb_q.pop_front();
                checkOutput("rdata", m_rdata, mon_item.data);
                checkOutput("rresp", {30'b0, m_rresp}, {30'b0, mon_item.resp});
                if (mon_item.clint) checkOutput("c_araddr_stable", c_araddr, mon_item.addr);
            end
        end
    end

    // Slave models: CLINT always ready with rvalid one cycle after AR; memory with programmable stalls.
    initial begin
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        c_arready = 1'b0; c_rvalid = 1'b0; rand_word = '0; mem_st = 0;
        wait_cnt = 0; lat_cnt = 0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                mem_st = 0;
                if (rand_mode) begin
                    s_arready = 1'($urandom_range(0, 1));
                    s_rvalid  = 1'($urandom_range(0, 1));
                    s_rdata   = $urandom;
                    s_rresp   = 2'($urandom_range(0, 3));
                    c_arready = 1'($urandom_range(0, 1));
                    c_rvalid  = 1'($urandom_range(0, 1));
                    rand_word = $urandom;
                end else begin
                    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
                    c_arready = 1'b0; c_rvalid = 1'b0; rand_word = '0;
                end
            end else begin
                c_arready = 1'b1;
                if (c_r_hs) c_rvalid = 1'b0;
                if (c_ar_hs) c_rvalid = 1'b1;
                case (mem_st)
                    0: if (s_arvalid) begin
                        wait_cnt  = mem_ar_wait;
                        s_arready = (wait_cnt == 0);
                        mem_st    = 1;
                    end
                    1: if (s_ar_hs) begin
                        s_arready = 1'b0;
                        if (mem_r_lat == 0) begin
                            s_rvalid = 1'b1; s_rdata = mem_data; s_rresp = mem_resp; mem_st = 3;
                        end else begin
                            lat_cnt = mem_r_lat; mem_st = 2;
                        end
                    end else if (wait_cnt > 0) begin
                        wait_cnt--;
                        if (wait_cnt == 0) s_arready = 1'b1;
                    end
                    2: begin
                        lat_cnt--;
                        if (lat_cnt == 0) begin
                            s_rvalid = 1'b1; s_rdata = mem_data; s_rresp = mem_resp; mem_st = 3;
                        end
                    end
                    3: if (s_r_hs) begin
                        s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; mem_st = 0;
                    end
                    default: mem_st = 0;
                endcase
            end
        end
    end

    task automatic issueRead(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp, input bit clint);
        sb_item_t it;
        int n;
        bit got;
        it.addr = addr; it.data = data; it.resp = resp; it.clint = clint;
        sb_q.push_back(it);
        m_araddr = addr; m_arvalid = 1'b1; m_rready = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clock); got = m_arready;
            @(posedge clock); #1;
            n++;
        end
        if (!got) checkOutput("ar_timeout", 32'd0, 32'd1);
        m_arvalid = 1'b0; m_araddr = '0;
    endtask

    task automatic waitResp(input int exp_lat);
        int lat;
        bit got;
        lat = 0; got = 1'b0;
        while (!got && lat < 50) begin
            lat++;
            @(negedge clock); got = m_rvalid;
            if (!got) begin @(posedge clock); #1; end
        end
        if (!got) checkOutput("resp_timeout", 32'd0, 32'd1);
        else if (exp_lat > 0) checkOutput("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic completeResp(input int delay, input logic [31:0] data);
        for (int i = 0; i < delay; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            checkOutput("hold_valid", {31'b0, m_rvalid}, 32'd1);
            checkOutput("hold_data", m_rdata, data);
        end
        @(posedge clock); #1; m_rready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1; m_rready = 1'b0;
        @(negedge clock);
        checkOutput("single_beat", {31'b0, m_rvalid}, 32'd0);
        checkOutput("arready_back", {31'b0, m_arready}, 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                                 input bit clint, input int delay, input int exp_lat);
        issueRead(addr, data, resp, clint);
        waitResp(exp_lat);
        completeResp(delay, data);
    endtask

    // Address outside both windows: DECERR when checking is built in, otherwise a plain memory read.
    task automatic readOutside(input logic [31:0] addr, input logic [31:0] data, input string name);
        watch_no_c = 1'b1; c_viol = 0; s_viol = 0;
`ifdef XBAR_DECERR_EN
        watch_no_s = 1'b1;
        applyStimulus(addr, 32'd0, 2'b11, 1'b0, 0, 1);
        checkOutput({name, "_no_slave_ar"}, 32'(s_viol), 32'd0);
`else
        mem_ar_wait = 0; mem_r_lat = 0; mem_data = data; mem_resp = 2'b00;
        applyStimulus(addr, data, 2'b00, 1'b0, 0, 2);
`endif
        watch_no_s = 1'b0; watch_no_c = 1'b0;
        checkOutput({name, "_no_clint_ar"}, 32'(c_viol), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; rand_mode = 1'b1;
        m_araddr = 32'ha000_0048; m_arvalid = 1'b1; m_rready = 1'b1;
        mem_ar_wait = 0; mem_r_lat = 0; mem_data = '0; mem_resp = 2'b00;
        watch_no_c = 1'b0; watch_no_s = 1'b0; c_viol = 0; s_viol = 0;
        #2 reset = 1'b0;

        $display("[TB] reset with random slave inputs");
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_arready", {31'b0, m_arready}, 32'd1);
        checkOutput("rst_rvalid", {31'b0, m_rvalid}, 32'd0);
        checkOutput("rst_rdata", m_rdata, 32'd0);
        checkOutput("rst_rresp", {30'b0, m_rresp}, 32'd0);
        checkOutput("rst_c_arvalid", {31'b0, c_arvalid}, 32'd0);
        checkOutput("rst_s_arvalid", {31'b0, s_arvalid}, 32'd0);
        checkOutput("rst_rready", {30'b0, c_rready, s_rready}, 32'd0);
        checkOutput("rst_addr", c_araddr | s_araddr, 32'd0);

        @(posedge clock); #1;
        rand_mode = 1'b0; m_arvalid = 1'b0; m_araddr = '0; m_rready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        $display("[TB] CLINT low and high words");
        applyStimulus(32'ha000_0048, MTIME_LO, 2'b00, 1'b1, 0, 2);
        repeat (100) @(posedge clock);
        #1;
        applyStimulus(32'ha000_004c, MTIME_HI, 2'b00, 1'b1, 1, 2);

        $display("[TB] memory read with AR and R stalls");
        mem_ar_wait = 3; mem_r_lat = 0; mem_data = 32'hdead_beef; mem_resp = 2'b00;
        watch_no_c = 1'b1; c_viol = 0;
        applyStimulus(32'h8000_0010, 32'hdead_beef, 2'b00, 1'b0, 2, 5);
        watch_no_c = 1'b0;
        checkOutput("mem_no_clint_ar", 32'(c_viol), 32'd0);

        $display("[TB] memory error response passes through");
        mem_ar_wait = 0; mem_r_lat = 1; mem_data = 32'hcafe_f00d; mem_resp = 2'b10;
        applyStimulus(32'h8000_0100, 32'hcafe_f00d, 2'b10, 1'b0, 0, 3);

        $display("[TB] address outside both windows");
        readOutside(32'h1000_0000, 32'h1111_2222, "outside");

        $display("[TB] CLINT window boundaries");
        readOutside(32'ha000_0047, 32'h5a5a_0047, "below_clint");
        readOutside(32'ha000_0050, 32'h5a5a_0050, "above_clint");
        readOutside(32'hffff_fffc, 32'h5a5a_fffc, "top_of_space");
        applyStimulus(32'ha000_004f, MTIME_HI, 2'b00, 1'b1, 0, 2);

        $display("[TB] reset asserted during response");
        issueRead(32'ha000_0048, MTIME_LO, 2'b00, 1'b1);
        waitResp(2);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_rvalid", {31'b0, m_rvalid}, 32'd0);
        checkOutput("midrst_arready", {31'b0, m_arready}, 32'd1);
        checkOutput("midrst_c_rready", {31'b0, c_rready}, 32'd0);
        checkOutput("midrst_c_araddr", c_araddr, 32'd0);
        dropped = sb_q.pop_back();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        applyStimulus(32'ha000_004c, MTIME_HI, 2'b00, 1'b1, 0, 2);
        mem_ar_wait = 1; mem_r_lat = 0; mem_data = 32'h0bad_f00d; mem_resp = 2'b00;
        applyStimulus(32'h87ff_fffc, 32'h0bad_f00d, 2'b00, 1'b0, 0, 3);

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_xbar.md
# ysyx_25040111_xbar

Read-channel address crossbar between the core's load/fetch read master and its two read slaves: the CLINT timer (mtime low/high words) and the main memory/SoC bus port. Accepts one read request at a time from the master, decodes the address, forwards it to exactly one slave, and returns that slave's data with a response code. Directly upstream of the CLINT; it holds the forwarded address stable for the whole transaction because the CLINT selects its read word combinationally from `araddr`.

## Interface
- `CLINT_BASE`, default 32'ha000_0048: base of the CLINT window (mtime low word; high word at +4).
- `CLINT_SIZE`, default 8: CLINT window size in bytes.
- `MEM_BASE`, default 32'h8000_0000: base of the memory window (used only with decode-error checking).
- `MEM_SIZE`, default 32'h0800_0000: memory window size in bytes.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m_araddr`  in  32  master read address.
- `m_arvalid`  in  1  master request valid.
- `m_arready`  out  1  crossbar can accept a request.
- `m_rdata`  out  32  read data to master.
- `m_rresp`  out  2  2'b00 OKAY, 2'b11 DECERR.
- `m_rvalid`  out  1  read data valid.
- `m_rready`  in  1  master accepts data.
- `c_araddr` / `c_arvalid` / `c_arready`  out/out/in  32/1/1  CLINT address channel.
- `c_rdata` / `c_rvalid` / `c_rready`  in/in/out  32/1/1  CLINT data channel.
- `s_araddr` / `s_arvalid` / `s_arready`  out/out/in  32/1/1  memory address channel.
- `s_rdata` / `s_rresp` / `s_rvalid` / `s_rready`  in/in/in/out  32/2/1/1  memory data channel.

## Operation
- States: IDLE, REQ, RESP, ERR. Registers: state, `addr_q` (32), `sel_q` (0 = memory, 1 = CLINT).
- Decode: CLINT hit iff `m_araddr - CLINT_BASE < CLINT_SIZE` (unsigned 32-bit, so no wrap false-hits); else memory.
- IDLE: `m_arready`=1. On `m_arvalid`: latch `addr_q`, `sel_q` → REQ (or ERR, see Configuration).
- REQ: assert `arvalid` of the selected slave only, address = `addr_q`. On that slave's `arready` → RESP. `m_arready`=0.
- RESP: `m_rvalid`/`m_rdata` mirror the selected slave; `m_rresp` = `s_rresp` for memory, 2'b00 for CLINT. Selected slave's `rready` = `m_rready`; unselected `rready`=0. On `m_rvalid & m_rready` → IDLE.
- `c_araddr` and `s_araddr` are driven from `addr_q` in REQ and RESP; 0 in IDLE/ERR.
- Unselected slave sees `arvalid`=0 and `rready`=0 always; its `rvalid` is ignored.
- ERR: `m_rvalid`=1, `m_rdata`=0, `m_rresp`=2'b11, no slave touched; on `m_rready` → IDLE.
- One outstanding transaction; new requests are not accepted until the current response completes.

## Timing
- Reset (`reset`=0, async): state IDLE, `addr_q`=0, `sel_q`=0. Outputs during/after reset: `m_arready`=1, `m_rvalid`=0, `m_rdata`=0, `m_rresp`=0, all slave `arvalid`/`rready`=0, slave addresses 0.
- Reset asserted mid-transaction: immediately IDLE; response is dropped, slave handshakes are deasserted.
- CLINT read (always-ready `c_arready`, CLINT registers `rvalid` one cycle after AR handshake): AR handshake cycle N, `c_arvalid` cycle N+1, `m_rvalid` cycle N+2. Memory: N+1 + slave AR wait + slave R latency.
- `m_rvalid` held with stable data while `m_rready`=0 (slave holds; crossbar adds no buffering).
- Request accepted in the cycle the previous response completes is not possible: IDLE is re-entered first; minimum back-to-back spacing 3 cycles for CLINT.

## Configuration
- `XBAR_DECERR_EN` defined: address outside both CLINT and `[MEM_BASE, MEM_BASE+MEM_SIZE)` goes IDLE → ERR; DECERR returned one cycle after AR handshake.
- Not defined: ERR state absent; every non-CLINT address goes to memory; `m_rresp` only reflects `s_rresp`.

## Test plan
- Reset: hold `reset`=0 with random slave inputs → `m_rvalid`=0, `c_arvalid`=`s_arvalid`=0, `m_arready`=1.
- CLINT low/high: read 32'ha000_0048 then 32'ha000_004c after 100 cycles → `m_rvalid` exactly 2 cycles after AR handshake, data = mtime[31:0] then mtime[63:32], `m_rresp`=0, `c_araddr` stable until R handshake.
- Memory with stalls: read 32'h8000_0010, `s_arready` low 3 cycles, `s_rvalid` with data 32'hdeadbeef, resp 0, `m_rready` low 2 cycles → data held, completes once, `c_arvalid` never asserted.
- Decode error (`XBAR_DECERR_EN`): read 32'h1000_0000 → `m_rvalid` next cycle, rdata 0, rresp 2'b11, no slave `arvalid`; without macro → forwarded to memory.
- Boundary: reads at 32'ha000_0047 and 32'ha000_0050 → memory; 32'ha000_004f → CLINT; 32'hffff_fffc → no false CLINT hit.
- Reset mid-RESP: assert `reset`=0 while `m_rvalid`=1 → all valids drop asynchronously; next read after release completes normally.
